// File: rtl/menu_processor.sv
// Menu screen processor: copies a text frame to the display region with blink and
// row-highlight transforms, and moves a menu cursor from keyboard interrupts.
module menu_processor #(
  parameter logic [15:0] SRC_BASE      = 16'h0800,
  parameter logic [15:0] DST_XOR       = 16'hA800,
  parameter int          FRAME_WORDS   = 1280,
  parameter int          ROW_WORDS     = 40,
  parameter int          BLINK_PERIOD  = 25,
  parameter logic [2:0]  BLINK_ATTR    = 3'b001,
  parameter int          N_ITEMS       = 4,
  parameter int          ITEM_ROW0     = 10,
  parameter int          ITEM_ROW_STEP = 2,
  parameter logic [15:0] HILITE_XOR    = 16'h7000,
  parameter logic [7:0]  KEY_UP        = 8'h75,
  parameter logic [7:0]  KEY_DOWN      = 8'h72,
  parameter logic [7:0]  KEY_SELECT    = 8'h5A,
  parameter int          TW            = $clog2(N_ITEMS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  output logic          SWITCH_REQUEST,
  output logic [TW-1:0] SWITCH_TARGET,
  output logic          FATAL_ERROR,
  output logic          MEM_ENABLE,
  output logic          MEM_WRITE,
  output logic [15:0]   MEM_ADDR,
  input  logic [15:0]   MEM_DATA_R,
  output logic [15:0]   MEM_DATA_W,
  input  logic          GPU_READY,
  output logic          GPU_DRAW,
  input  logic [7:0]    KBD_KEY,
  input  logic [1:0]    INT_IRQ,
  output logic          INT_IACK,
  output logic          INT_IEND
);

  // state    | meaning
  // S_INIT   | clear working registers
  // S_IDLE   | wait for an interrupt
  // S_FACK   | acknowledge frame irq, advance blink counter
  // S_CHK    | draw frame if GPU ready, else skip
  // S_RD     | read source word
  // S_LD     | capture read data
  // S_MOD    | blank / highlight the word
  // S_WR     | write word to display region
  // S_NXT    | advance index, column, row
  // S_DRAW   | pulse GPU draw
  // S_END    | interrupt end
  // S_KACK   | acknowledge keyboard irq, latch key
  // S_KEND   | interrupt end, act on key
  // S_SWITCH | hold switch request
  // S_FATAL  | hold fatal error
  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_FACK, S_CHK, S_RD, S_LD, S_MOD, S_WR, S_NXT,
    S_DRAW, S_END, S_KACK, S_KEND, S_SWITCH, S_FATAL
  } state_t;

  localparam logic [15:0]   LAST_WORD = 16'(FRAME_WORDS - 1);
  localparam logic [15:0]   LAST_COL  = 16'(ROW_WORDS - 1);
  localparam logic [15:0]   LAST_BLK  = 16'(BLINK_PERIOD - 1);
  localparam logic [TW-1:0] LAST_CUR  = TW'(N_ITEMS - 1);

  state_t        state;
  logic [15:0]   buffer;
  logic [15:0]   blink_cnt;
  logic          visible;
  logic [TW-1:0] cursor;
  logic [15:0]   index;
  logic [15:0]   column;
  logic [15:0]   row;
  logic [7:0]    kbuf;
  logic [15:0]   src_addr;
  logic [15:0]   hl_row;

  assign src_addr = SRC_BASE + index;
  assign hl_row   = 16'(ITEM_ROW0) + 16'(cursor) * 16'(ITEM_ROW_STEP);

  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      state     <= S_INIT;
      buffer    <= '0;
      blink_cnt <= '0;
      visible   <= 1'b0;
      cursor    <= '0;
      index     <= '0;
      column    <= '0;
      row       <= '0;
      kbuf      <= '0;
    end else begin
      case (state)
        S_INIT: begin
          buffer    <= '0;
          blink_cnt <= '0;
          visible   <= 1'b0;
          cursor    <= '0;
          index     <= '0;
          column    <= '0;
          row       <= '0;
          state     <= S_IDLE;
        end
        S_IDLE: begin
          case (INT_IRQ)
            2'd0:    state <= S_FACK;
            2'd1:    state <= S_KACK;
            2'd3:    state <= S_FATAL;
            default: state <= S_IDLE;
          endcase
        end
        S_FACK: begin
          if (blink_cnt == '0) visible <= ~visible;
          blink_cnt <= (blink_cnt == LAST_BLK) ? '0 : blink_cnt + 16'd1;
          state     <= S_CHK;
        end
        S_CHK: begin
          if (GPU_READY) begin
            index  <= '0;
            column <= '0;
            row    <= '0;
            state  <= S_RD;
          end else begin
            state  <= S_END;
          end
        end
        S_RD: state <= S_LD;
        S_LD: begin
          buffer <= MEM_DATA_R;
          state  <= S_MOD;
        end
        S_MOD: begin
          // blanking takes priority over highlighting
          if (buffer[10:8] == BLINK_ATTR && !visible) buffer <= '0;
          else if (row == hl_row)                     buffer <= buffer ^ HILITE_XOR;
          state <= S_WR;
        end
        S_WR: state <= S_NXT;
        S_NXT: begin
          index <= index + 16'd1;
          if (column == LAST_COL) begin
            column <= '0;
            row    <= row + 16'd1;
          end else begin
            column <= column + 16'd1;
          end
          state <= (index == LAST_WORD) ? S_DRAW : S_RD;
        end
        S_DRAW: state <= S_END;
        S_END:  state <= S_IDLE;
        S_KACK: begin
          kbuf  <= KBD_KEY;
          state <= S_KEND;
        end
        S_KEND: begin
          if (kbuf == KEY_UP) begin
            cursor <= (cursor == '0) ? LAST_CUR : cursor - TW'(1);
            state  <= S_IDLE;
          end else if (kbuf == KEY_DOWN) begin
            cursor <= (cursor == LAST_CUR) ? '0 : cursor + TW'(1);
            state  <= S_IDLE;
          end else if (kbuf == KEY_SELECT) begin
            state  <= S_SWITCH;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_SWITCH: state <= S_SWITCH;
        S_FATAL:  state <= S_FATAL;
        default:  state <= S_INIT;
      endcase
    end
  end

  always_comb begin
    SWITCH_REQUEST = 1'b0;
    FATAL_ERROR    = 1'b0;
    MEM_ENABLE     = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDR       = 16'h0000;
    GPU_DRAW       = 1'b0;
    INT_IACK       = 1'b0;
    INT_IEND       = 1'b0;
    case (state)
      S_IDLE:   MEM_ADDR = SRC_BASE;
      S_FACK:   INT_IACK = 1'b1;
      S_KACK:   INT_IACK = 1'b1;
      S_RD: begin
        MEM_ENABLE = 1'b1;
        MEM_ADDR   = src_addr;
      end
      S_WR: begin
        MEM_ENABLE = 1'b1;
        MEM_WRITE  = 1'b1;
        MEM_ADDR   = src_addr ^ DST_XOR;
      end
      S_DRAW:   GPU_DRAW       = 1'b1;
      S_END:    INT_IEND       = 1'b1;
      S_KEND:   INT_IEND       = 1'b1;
      S_SWITCH: SWITCH_REQUEST = 1'b1;
      S_FATAL:  FATAL_ERROR    = 1'b1;
      default: ;
    endcase
  end

  assign SWITCH_TARGET = cursor;
  assign MEM_DATA_W    = buffer;

endmodule

// File: tb/tb_menu_processor.sv
// Scoreboard bench for menu_processor with a small frame (8 words, 2 per row, 2 items).
module tb_menu_processor;
  localparam int FW = 8, RW = 2, NI = 2, BP = 2, R0 = 1, RS = 1, TW = 1;

  logic          CLK = 1'b0;
  logic          RESET, ENABLE;
  logic          SWITCH_REQUEST;
  logic [TW-1:0] SWITCH_TARGET;
  logic          FATAL_ERROR, MEM_ENABLE, MEM_WRITE;
  logic [15:0]   MEM_ADDR, MEM_DATA_W;
  logic [15:0]   MEM_DATA_R = 16'h0000;
  logic          GPU_READY, GPU_DRAW;
  logic [7:0]    KBD_KEY;
  logic [1:0]    INT_IRQ;
  logic          INT_IACK, INT_IEND;

  menu_processor #(
    .FRAME_WORDS(FW), .ROW_WORDS(RW), .BLINK_PERIOD(BP), .N_ITEMS(NI),
    .ITEM_ROW0(R0), .ITEM_ROW_STEP(RS)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .SWITCH_REQUEST(SWITCH_REQUEST), .SWITCH_TARGET(SWITCH_TARGET),
    .FATAL_ERROR(FATAL_ERROR), .MEM_ENABLE(MEM_ENABLE), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR(MEM_ADDR), .MEM_DATA_R(MEM_DATA_R), .MEM_DATA_W(MEM_DATA_W),
    .GPU_READY(GPU_READY), .GPU_DRAW(GPU_DRAW), .KBD_KEY(KBD_KEY),
    .INT_IRQ(INT_IRQ), .INT_IACK(INT_IACK), .INT_IEND(INT_IEND)
  );

  always #5 CLK = ~CLK;

  logic [15:0] src_pat [FW];
  always @(posedge CLK)
    if (MEM_ENABLE && !MEM_WRITE) MEM_DATA_R <= src_pat[MEM_ADDR[2:0]];

  int checks = 0, errors = 0;
  bit tb_vis = 1'b0;
  int tb_cnt = 0, tb_cursor = 0;
  logic [31:0] exp_wr_q[$];
  logic [31:0] obs_wr_q[$];
  logic [15:0] obs_rd_q[$];
  int exp_cur_q[$];
  int n_draw, n_mem, n_fatal, n_ack, t_ack, t_end;

  function automatic logic [15:0] model_word(input logic [15:0] d, input int row);
    if (d[10:8] == 3'b001 && !tb_vis) return 16'h0000;
    if (row == R0 + tb_cursor * RS)   return d ^ 16'h7000;
    return d;
  endfunction

  task automatic blink_step();
    if (tb_cnt == 0) tb_vis = !tb_vis;
    tb_cnt = (tb_cnt == BP - 1) ? 0 : tb_cnt + 1;
  endtask

  task automatic push_frame(input int nwords);
    for (int w = 0; w < nwords; w++) begin
      logic [15:0] a;
      a = (16'h0800 + 16'(w)) ^ 16'hA800;
      exp_wr_q.push_back({a, model_word(src_pat[w], w / RW)});
    end
  endtask

  task automatic model_reset();
    tb_vis = 1'b0; tb_cnt = 0; tb_cursor = 0;
  endtask

  task automatic irq_txn(input logic [1:0] code, input logic [7:0] key, input int budget);
    obs_wr_q.delete(); obs_rd_q.delete();
    n_draw = 0; n_mem = 0; n_fatal = 0; n_ack = 0; t_ack = -1; t_end = -1;
    @(negedge CLK);
    INT_IRQ = code; KBD_KEY = key;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (MEM_ENABLE) n_mem++;
      if (MEM_ENABLE && !MEM_WRITE) obs_rd_q.push_back(MEM_ADDR);
      if (MEM_ENABLE && MEM_WRITE)  obs_wr_q.push_back({MEM_ADDR, MEM_DATA_W});
      if (GPU_DRAW) n_draw++;
      if (FATAL_ERROR) n_fatal++;
      if (INT_IACK) begin n_ack++; t_ack = i; INT_IRQ = 2'd2; end
      if (INT_IEND) begin t_end = i; break; end
    end
    INT_IRQ = 2'd2;
  endtask

  task automatic test_reset();
    RESET = 1'b1; ENABLE = 1'b1; GPU_READY = 1'b1; KBD_KEY = 8'h00; INT_IRQ = 2'd2;
    repeat (3) @(negedge CLK);
    checks++;
    if ({SWITCH_REQUEST, SWITCH_TARGET, FATAL_ERROR, MEM_ENABLE, MEM_WRITE, MEM_ADDR,
         MEM_DATA_W, GPU_DRAW, INT_IACK, INT_IEND} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h data=%h sw=%b fatal=%b en=%b, need all zero",
               MEM_ADDR, MEM_DATA_W, SWITCH_REQUEST, FATAL_ERROR, MEM_ENABLE);
    end
    RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (MEM_ADDR !== 16'h0800) begin
      errors++; $display("FAIL reset_idle_addr: got %h need 0800", MEM_ADDR);
    end
    model_reset();
  endtask

  task automatic test_frame(input string name);
    blink_step();
    push_frame(FW);
    irq_txn(2'd0, 8'h00, 200);
    checks++;
    if (t_end < 0) begin errors++; $display("FAIL %s_timeout: no IEND within 200 cycles", name); end
    checks++;
    if (obs_rd_q.size() != FW) begin
      errors++; $display("FAIL %s_reads: got %0d need %0d", name, obs_rd_q.size(), FW);
    end
    for (int i = 0; i < obs_rd_q.size(); i++) begin
      checks++;
      if (obs_rd_q[i] !== 16'h0800 + 16'(i)) begin
        errors++; $display("FAIL %s_rd_addr%0d: got %h need %h", name, i, obs_rd_q[i], 16'h0800 + 16'(i));
      end
    end
    while (obs_wr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_wr_q.pop_front();
      checks++;
      if (exp_wr_q.size() == 0) begin
        errors++; $display("FAIL %s_extra_write: got %h need none", name, o);
      end else begin
        e = exp_wr_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL %s_write: got addr/data %h need %h", name, o, e);
        end
      end
    end
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("FAIL %s_missing_writes: %0d left, need 0", name, exp_wr_q.size());
      exp_wr_q.delete();
    end
    checks++;
    if (n_draw != 1) begin errors++; $display("FAIL %s_draw: got %0d need 1", name, n_draw); end
    checks++;
    if (t_end - t_ack != 5 * FW + 3) begin
      errors++; $display("FAIL %s_latency: got %0d need %0d", name, t_end - t_ack, 5 * FW + 3);
    end
  endtask

  task automatic test_gpu_not_ready();
    GPU_READY = 1'b0;
    blink_step();
    irq_txn(2'd0, 8'h00, 20);
    checks++;
    if (t_ack < 0 || t_end < 0 || t_end - t_ack > 3) begin
      errors++; $display("FAIL skip_iend: got ack=%0d end=%0d need end within 3 of ack", t_ack, t_end);
    end
    checks++;
    if (n_mem != 0 || n_draw != 0) begin
      errors++; $display("FAIL skip_activity: got mem=%0d draw=%0d need 0 0", n_mem, n_draw);
    end
    GPU_READY = 1'b1;
  endtask

  task automatic test_keys();
    logic [7:0] keys [4];
    keys[0] = 8'h75; keys[1] = 8'h72; keys[2] = 8'h1C; keys[3] = 8'h72;
    for (int k = 0; k < 4; k++) begin
      if (keys[k] == 8'h75) tb_cursor = (tb_cursor == 0) ? NI - 1 : tb_cursor - 1;
      else if (keys[k] == 8'h72) tb_cursor = (tb_cursor == NI - 1) ? 0 : tb_cursor + 1;
      exp_cur_q.push_back(tb_cursor);
      irq_txn(2'd1, keys[k], 20);
      checks++;
      if (n_ack != 1 || t_end != t_ack + 1) begin
        errors++; $display("FAIL key%0d_handshake: got ack=%0d at %0d end at %0d need ack then end", k, n_ack, t_ack, t_end);
      end
      @(negedge CLK);
      begin
        int e;
        e = exp_cur_q.pop_front();
        checks++;
        if (SWITCH_TARGET !== TW'(e) || SWITCH_REQUEST !== 1'b0) begin
          errors++; $display("FAIL key%0d_cursor: got %0d req=%b need %0d req=0", k, SWITCH_TARGET, SWITCH_REQUEST, e);
        end
      end
    end
  endtask

  task automatic test_select();
    int bad;
    bad = 0;
    irq_txn(2'd1, 8'h5A, 20);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (!(SWITCH_REQUEST === 1'b1 && SWITCH_TARGET === TW'(tb_cursor) &&
            MEM_ENABLE === 1'b0 && INT_IACK === 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL select_hold: got %0d bad cycles need 0 (target %0d)", bad, tb_cursor);
    end
    ENABLE = 1'b0;
    @(negedge CLK);
    checks++;
    if (SWITCH_REQUEST !== 1'b0 || SWITCH_TARGET !== '0) begin
      errors++; $display("FAIL select_disable: got req=%b tgt=%0d need 0 0", SWITCH_REQUEST, SWITCH_TARGET);
    end
    model_reset();
    ENABLE = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (MEM_ADDR !== 16'h0800) begin
      errors++; $display("FAIL select_reenter_idle: got %h need 0800", MEM_ADDR);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit hit;
    int wrs, ends;
    hit = 1'b0; wrs = 0; ends = 0;
    obs_wr_q.delete();
    blink_step();
    push_frame(3);
    @(negedge CLK);
    INT_IRQ = 2'd0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (INT_IACK) INT_IRQ = 2'd2;
      if (MEM_ENABLE && MEM_WRITE) obs_wr_q.push_back({MEM_ADDR, MEM_DATA_W});
      if (MEM_ENABLE && !MEM_WRITE && MEM_ADDR == 16'h0803) begin
        RESET = 1'b1; hit = 1'b1; break;
      end
    end
    INT_IRQ = 2'd2;
    checks++;
    if (!hit) begin errors++; $display("FAIL midreset_reach_word3: got none need read of 0803"); end
    @(negedge CLK);
    checks++;
    if ({SWITCH_REQUEST, SWITCH_TARGET, FATAL_ERROR, MEM_ENABLE, MEM_WRITE, MEM_ADDR,
         MEM_DATA_W, GPU_DRAW, INT_IACK, INT_IEND} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got addr=%h data=%h en=%b need all zero", MEM_ADDR, MEM_DATA_W, MEM_ENABLE);
    end
    RESET = 1'b0;
    model_reset();
    while (obs_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_wr_q.pop_front();
      e = exp_wr_q.pop_front();
      checks++;
      if (o !== e) begin errors++; $display("FAIL midreset_write: got %h need %h", o, e); end
    end
    checks++;
    if (obs_wr_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++; $display("FAIL midreset_write_count: got extra=%0d missing=%0d need 0 0", obs_wr_q.size(), exp_wr_q.size());
      obs_wr_q.delete(); exp_wr_q.delete();
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (MEM_ENABLE && MEM_WRITE) wrs++;
      if (INT_IEND) ends++;
    end
    checks++;
    if (wrs != 0 || ends != 0) begin
      errors++; $display("FAIL midreset_after: got writes=%0d iend=%0d need 0 0", wrs, ends);
    end
    checks++;
    if (MEM_ADDR !== 16'h0800) begin
      errors++; $display("FAIL midreset_idle: got %h need 0800", MEM_ADDR);
    end
  endtask

  task automatic test_fatal();
    irq_txn(2'd3, 8'h00, 20);
    checks++;
    if (n_fatal != 20 || n_ack != 0 || n_mem != 0 || t_end != -1) begin
      errors++; $display("FAIL fatal_hold: got fatal=%0d ack=%0d mem=%0d end=%0d need 20 0 0 -1",
                         n_fatal, n_ack, n_mem, t_end);
    end
    RESET = 1'b1;
    @(negedge CLK);
    checks++;
    if (FATAL_ERROR !== 1'b0) begin errors++; $display("FAIL fatal_reset: got %b need 0", FATAL_ERROR); end
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (MEM_ADDR !== 16'h0800) begin errors++; $display("FAIL fatal_idle: got %h need 0800", MEM_ADDR); end
  endtask

  initial begin
    for (int i = 0; i < FW; i++) src_pat[i] = 16'h0141;
    test_reset();
    test_frame("frame_visible");
    test_frame("frame_repeat");
    test_frame("frame_hidden");
    test_gpu_not_ready();
    test_keys();
    src_pat[0] = 16'h0141; src_pat[1] = 16'h0241; src_pat[2] = 16'h1234; src_pat[3] = 16'hABCD;
    src_pat[4] = 16'h0155; src_pat[5] = 16'h0200; src_pat[6] = 16'h8101; src_pat[7] = 16'h00FF;
    test_frame("mixed_a");
    test_frame("mixed_b");
    test_frame("mixed_c");
    test_select();
    test_reset_mid_frame();
    test_fatal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
